// File: rtl/sat_accumulator.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : sat_accumulator                                          |
// | Description : Two-stage framed accumulator. Stage 1 reduces LANES      |
// |               signed lanes to a full-precision sum; stage 2 adds the   |
// |               sum into a saturating ACC_W accumulator and reports the  |
// |               clamped frame total with a sticky saturation flag.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module sat_accumulator #(
   parameter int IN_W  = 16,
   parameter int LANES = 4,
   parameter int ACC_W = 18
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic [LANES*IN_W-1:0]   in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   output logic signed [ACC_W-1:0] out_data,
   output logic                    out_sat
);

   // Full-precision lane sum width: LANES values never need more than
   // log2(LANES) growth bits, so this sum is exact.
   localparam int c_SUM_W = IN_W + $clog2(LANES);
   localparam int c_EXT_W = c_SUM_W - IN_W;
   // The stage-2 adder works one bit wider than the accumulator so that
   // overflow shows up as a mismatch of the two top bits.
   localparam int c_T_W   = ACC_W + 1;
   localparam int c_SX_W  = c_T_W - c_SUM_W;

   localparam logic signed [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   // ----------------------------------------------------------------------
   // Lane unpacking
   // ----------------------------------------------------------------------
   logic signed [IN_W-1:0] w_lane [LANES];

   genvar g_k;
   generate
      for (g_k = 0; g_k < LANES; g_k++) begin : g_lane
         assign w_lane[g_k] = in_data[g_k*IN_W +: IN_W];
      end
   endgenerate

   // ----------------------------------------------------------------------
   // Stage 1: full-precision lane reduction
   // ----------------------------------------------------------------------
   logic signed [c_SUM_W-1:0] w_sum;
   logic signed [c_SUM_W-1:0] r_s1_sum;
   logic                      r_s1_valid;
   logic                      r_s1_last;

   // Sign-extend every lane to the sum width and add them up.
   always_comb begin
      w_sum = '0;
      for (int k = 0; k < LANES; k++) begin
         w_sum = w_sum + {{c_EXT_W{w_lane[k][IN_W-1]}}, w_lane[k]};
      end
   end

   // Capture one beat; an idle cycle becomes a bubble and its in_last is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_sum   <= '0;
      end else begin
         r_s1_valid <= in_valid;
         r_s1_last  <= in_valid & in_last;
         if (in_valid) begin
            r_s1_sum <= w_sum;
         end
      end
   end

   // ----------------------------------------------------------------------
   // Stage 2: saturating accumulate
   // ----------------------------------------------------------------------
   logic signed [ACC_W-1:0] r_acc;
   logic                    r_sat_f;

   logic signed [c_T_W-1:0] w_acc_ext;
   logic signed [c_T_W-1:0] w_sum_ext;
   logic signed [c_T_W-1:0] w_t;
   logic                    w_ovf_pos;
   logic                    w_ovf_neg;
   logic                    w_clamp;
   logic signed [ACC_W-1:0] w_result;

   // Widen both operands, add, and clamp to the accumulator range.
   always_comb begin
      w_acc_ext = {r_acc[ACC_W-1], r_acc};
      w_sum_ext = {{c_SX_W{r_s1_sum[c_SUM_W-1]}}, r_s1_sum};
      w_t       = w_acc_ext + w_sum_ext;
      // Both operands fit in ACC_W bits, so the true sum always fits in
      // ACC_W+1 bits and a top-bit mismatch is an exact overflow test.
      w_ovf_pos = ~w_t[ACC_W] &  w_t[ACC_W-1];
      w_ovf_neg =  w_t[ACC_W] & ~w_t[ACC_W-1];
      w_clamp   = w_ovf_pos | w_ovf_neg;
      if (w_ovf_pos) begin
         w_result = c_ACC_MAX;
      end else if (w_ovf_neg) begin
         w_result = c_ACC_MIN;
      end else begin
         w_result = w_t[ACC_W-1:0];
      end
   end

   // Accumulate mid-frame beats; on the last beat publish the result and
   // restart from zero so a back-to-back frame starts clean.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc     <= '0;
         r_sat_f   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (r_s1_valid) begin
            if (r_s1_last) begin
               out_data  <= w_result;
               out_sat   <= r_sat_f | w_clamp;
               out_valid <= 1'b1;
               r_acc     <= '0;
               r_sat_f   <= 1'b0;
            end else begin
               r_acc     <= w_result;
               r_sat_f   <= r_sat_f | w_clamp;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sat_accumulator.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_sat_accumulator                                       |
// | Description : Directed and randomized bench for sat_accumulator with   |
// |               a frame-level arithmetic reference model.                |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_sat_accumulator;

   localparam int     IN_W    = 16;
   localparam int     LANES   = 4;
   localparam int     ACC_W   = 18;
   localparam longint ACC_MAX = 131071;
   localparam longint ACC_MIN = -131072;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    in_valid;
   logic [LANES*IN_W-1:0]   in_data;
   logic                    in_last;
   logic                    out_valid;
   logic signed [ACC_W-1:0] out_data;
   logic                    out_sat;

   int checks = 0;
   int errors = 0;
   int step_no = 0;

   // Reference model state: running frame value and sticky flag, the
   // result of a frame whose last beat has just been presented, and the
   // output values the consumer should currently see.
   longint m_acc  = 0;
   bit     m_sat  = 1'b0;
   bit     pend_v = 1'b0;
   longint pend_d = 0;
   bit     pend_s = 1'b0;
   longint exp_d  = 0;
   bit     exp_s  = 1'b0;

   sat_accumulator #(
      .IN_W  (IN_W),
      .LANES (LANES),
      .ACC_W (ACC_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   function automatic logic [LANES*IN_W-1:0] mk(input int a, input int b, input int c, input int d);
      return {d[15:0], c[15:0], b[15:0], a[15:0]};
   endfunction

   // Compare outputs with the model's view of what the consumer should see.
   task automatic check_outputs(input bit want_v);
      logic signed [ACC_W-1:0] want_d;
      want_d = ACC_W'(exp_d);
      checks++;
      assert (out_valid === want_v) else begin
         errors++;
         $error("FAIL out_valid step %0d: got %b expected %b", step_no, out_valid, want_v);
      end
      checks++;
      assert (out_data === want_d) else begin
         errors++;
         $error("FAIL out_data step %0d: got %0d expected %0d", step_no, out_data, want_d);
      end
      checks++;
      assert (out_sat === exp_s) else begin
         errors++;
         $error("FAIL out_sat step %0d: got %b expected %b", step_no, out_sat, exp_s);
      end
   endtask

   // Directed checks against hand-computed frame results.
   task automatic expect_frame(input string tag, input longint d, input bit s);
      logic signed [ACC_W-1:0] want_d;
      want_d = ACC_W'(d);
      checks++;
      assert (out_valid === 1'b1) else begin
         errors++;
         $error("FAIL %s pulse: got %b expected 1", tag, out_valid);
      end
      checks++;
      assert (out_data === want_d) else begin
         errors++;
         $error("FAIL %s data: got %0d expected %0d", tag, out_data, want_d);
      end
      checks++;
      assert (out_sat === s) else begin
         errors++;
         $error("FAIL %s sat: got %b expected %b", tag, out_sat, s);
      end
   endtask

   // Present one input cycle, advance the model, clock, then check.
   task automatic step(input bit v, input bit l, input logic [LANES*IN_W-1:0] d);
      bit     cur_v;
      longint s;
      longint t;
      longint r;
      bit     c;
      step_no++;
      cur_v = pend_v;
      if (pend_v) begin
         exp_d = pend_d;
         exp_s = pend_s;
      end
      pend_v = 1'b0;
      if (v) begin
         s = 0;
         for (int k = 0; k < LANES; k++) begin
            s += longint'($signed(d[k*IN_W +: IN_W]));
         end
         t = m_acc + s;
         c = 1'b0;
         if (t > ACC_MAX) begin
            r = ACC_MAX;
            c = 1'b1;
         end else if (t < ACC_MIN) begin
            r = ACC_MIN;
            c = 1'b1;
         end else begin
            r = t;
         end
         if (l) begin
            pend_v = 1'b1;
            pend_d = r;
            pend_s = m_sat | c;
            m_acc  = 0;
            m_sat  = 1'b0;
         end else begin
            m_acc = r;
            m_sat = m_sat | c;
         end
      end
      in_valid = v;
      in_last  = l;
      in_data  = d;
      @(posedge clk);
      #1;
      check_outputs(cur_v);
   endtask

   // One reset edge with a live-looking beat on the inputs, which must be ignored.
   task automatic do_reset();
      step_no++;
      reset    = 1'b1;
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = {$urandom, $urandom};
      @(posedge clk);
      #1;
      m_acc  = 0;
      m_sat  = 1'b0;
      pend_v = 1'b0;
      exp_d  = 0;
      exp_s  = 1'b0;
      check_outputs(1'b0);
      reset    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      logic [LANES*IN_W-1:0] d;
      logic [LANES*IN_W-1:0] zero;
      int                    mode;
      bit                    v;
      bit                    l;
      zero     = '0;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;

      // Reset state
      do_reset();
      do_reset();

      // One-beat frame {1,2,3,4}
      step(1'b1, 1'b1, mk(1, 2, 3, 4));
      step(1'b0, 1'b0, zero);
      expect_frame("single_beat", 10, 1'b0);
      step(1'b0, 1'b0, zero);

      // Positive saturation over two beats
      step(1'b1, 1'b0, mk(32767, 32767, 32767, 32767));
      step(1'b1, 1'b1, mk(32767, 32767, 32767, 32767));
      step(1'b0, 1'b0, zero);
      expect_frame("pos_sat", 131071, 1'b1);

      // Most negative value exactly, then negative saturation
      step(1'b1, 1'b1, mk(-32768, -32768, -32768, -32768));
      step(1'b0, 1'b0, zero);
      expect_frame("neg_exact", -131072, 1'b0);
      step(1'b1, 1'b0, mk(-32768, -32768, -32768, -32768));
      step(1'b1, 1'b1, mk(-32768, -32768, -32768, -32768));
      step(1'b0, 1'b0, zero);
      expect_frame("neg_sat", -131072, 1'b1);

      // Clamp then continue, followed by a back-to-back clean frame
      step(1'b1, 1'b0, mk(32767, 32767, 32767, 32767));
      step(1'b1, 1'b0, mk(32767, 32767, 32767, 32767));
      step(1'b1, 1'b1, mk(-32767, -32767, -32767, -32767));
      step(1'b1, 1'b1, mk(1, 0, 0, 0));
      expect_frame("sat_continue", 3, 1'b1);
      step(1'b0, 1'b0, zero);
      expect_frame("after_sat_frame", 1, 1'b0);

      // Bubbles, including an unqualified in_last
      step(1'b1, 1'b0, mk(5, 0, 0, 0));
      step(1'b0, 1'b1, mk(99, 99, 99, 99));
      step(1'b0, 1'b0, zero);
      step(1'b1, 1'b1, mk(7, 0, 0, 0));
      step(1'b0, 1'b0, zero);
      expect_frame("bubbles", 12, 1'b0);
      step(1'b0, 1'b0, zero);

      // Reset in the middle of a frame
      step(1'b1, 1'b0, mk(100, 0, 0, 0));
      step(1'b1, 1'b0, mk(100, 0, 0, 0));
      do_reset();
      step(1'b1, 1'b1, mk(9, 0, 0, 0));
      step(1'b0, 1'b0, zero);
      expect_frame("after_reset", 9, 1'b0);

      // Randomized traffic with extreme values mixed in to force clamps
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) < 2) begin
            do_reset();
         end else begin
            v    = ($urandom_range(0, 99) < 75);
            l    = ($urandom_range(0, 3) == 0);
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
               d = {$urandom, $urandom};
            end else if (mode == 1) begin
               if ($urandom_range(0, 1) == 1) begin
                  d = mk(32767, 32767, 32767, 32767);
               end else begin
                  d = mk(-32768, -32768, -32768, -32768);
               end
            end else begin
               d = mk($urandom_range(0, 40) - 20, $urandom_range(0, 40) - 20,
                      $urandom_range(0, 40) - 20, $urandom_range(0, 40) - 20);
            end
            step(v, l, d);
         end
      end

      // Drain the pipeline
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, zero);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
